mem_controller: RTL

- Responder-side data-memory controller: terminates per-thread read/write valid/ready requests issued by compute cores' load/store units.
- Multiplexes NUM_CONSUMERS consumer request ports onto NUM_CHANNELS external memory channels using round-robin arbitration.
- Sits between the cores' data_mem_* buses and global data memory. One instance serves all threads of all cores.

---
 rtl/gpu_mem_pkg.sv | 15 +
 rtl/mem_channel.sv | 110 +++++++++++
 rtl/mem_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the data-memory controller.
package gpu_mem_pkg;

    localparam int unsigned DefaultAddrBits = 8;
    localparam int unsigned DefaultDataBits = 8;

    typedef enum logic [2:0] {
        StIdle          = 3'd0,
        StReadWaiting   = 3'd1,
        StWriteWaiting  = 3'd2,
        StReadRelaying  = 3'd3,
        StWriteRelaying = 3'd4
    } channel_state_t;

endpackage

// File: rtl/mem_channel.sv
// One memory channel: owns a granted consumer request from acceptance until the
// consumer drops its valid after seeing ready.
module mem_channel
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DefaultAddrBits,
    parameter int unsigned DATA_BITS = DefaultDataBits,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 grant_i,
    input  logic                 grant_write_i,
    input  logic [IDX_W-1:0]     grant_idx_i,
    input  logic [ADDR_BITS-1:0] grant_addr_i,
    input  logic [DATA_BITS-1:0] grant_data_i,
    input  logic                 cons_read_valid_i,
    input  logic                 cons_write_valid_i,
    input  logic                 mem_read_ready_i,
    input  logic [DATA_BITS-1:0] mem_read_data_i,
    input  logic                 mem_write_ready_i,
    output logic                 idle_o,
    output logic                 release_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 read_ready_o,
    output logic [DATA_BITS-1:0] read_data_o,
    output logic                 write_ready_o,
    output logic                 mem_read_valid_o,
    output logic [ADDR_BITS-1:0] mem_read_address_o,
    output logic                 mem_write_valid_o,
    output logic [ADDR_BITS-1:0] mem_write_address_o,
    output logic [DATA_BITS-1:0] mem_write_data_o
);

    channel_state_t       state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    // Holds write data while writing, then the returned read data while relaying.
    logic [DATA_BITS-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        release_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_i) begin
                    state_d = grant_write_i ? StWriteWaiting : StReadWaiting;
                    idx_d   = grant_idx_i;
                    addr_d  = grant_addr_i;
                    data_d  = grant_write_i ? grant_data_i : '0;
                end
            end
            StReadWaiting: begin
                if (mem_read_ready_i) begin
                    data_d  = mem_read_data_i;
                    state_d = StReadRelaying;
                end
            end
            StWriteWaiting: begin
                if (mem_write_ready_i) begin
                    state_d = StWriteRelaying;
                end
            end
            StReadRelaying: begin
                if (!cons_read_valid_i) begin
                    state_d   = StIdle;
                    release_o = 1'b1;
                end
            end
            StWriteRelaying: begin
                if (!cons_write_valid_i) begin
                    state_d   = StIdle;
                    release_o = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idle_o              = (state_q == StIdle);
        idx_o               = idx_q;
        read_ready_o        = (state_q == StReadRelaying);
        read_data_o         = read_ready_o ? data_q : '0;
        write_ready_o       = (state_q == StWriteRelaying);
        mem_read_valid_o    = (state_q == StReadWaiting);
        mem_read_address_o  = mem_read_valid_o ? addr_q : '0;
        mem_write_valid_o   = (state_q == StWriteWaiting);
        mem_write_address_o = mem_write_valid_o ? addr_q : '0;
        mem_write_data_o    = mem_write_valid_o ? data_q : '0;
    end

endmodule

// File: rtl/mem_controller.sv
// Round-robin multiplexer of per-thread load/store requests onto memory channels.
// Holds the claim mask and rr pointer; each channel runs its own FSM.
module mem_controller
    import gpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_BITS     = DefaultAddrBits,
    parameter int unsigned DATA_BITS     = DefaultDataBits,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter bit          WRITE_ENABLE  = 1'b1
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

    localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    logic [NUM_CONSUMERS-1:0] claim_q, claim_d, rd_req, wr_req, release_mask;
    logic [IdxW-1:0]          rr_q, rr_d;

    logic [NUM_CHANNELS-1:0]                 grant, grant_write, ch_idle, ch_release;
    logic [NUM_CHANNELS-1:0][IdxW-1:0]       grant_idx, ch_idx;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  grant_addr, ch_mwaddr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  grant_data, ch_rdata, ch_mwdata;
    logic [NUM_CHANNELS-1:0]                 ch_rd_v, ch_wr_v, ch_rd_rdy, ch_wr_rdy, ch_mwv;

    assign rd_req = consumer_read_valid;
    assign wr_req = WRITE_ENABLE ? consumer_write_valid : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            claim_q <= '0;
            rr_q    <= '0;
        end else begin
            claim_q <= claim_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        release_mask = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_release[c]) begin
                release_mask[ch_idx[c]] = 1'b1;
            end
        end
    end

    // Channels arbitrate in index order; claim and pointer ripple between them.
    always_comb begin
        int unsigned start;
        int unsigned j;
        start       = 0;
        j           = 0;
        claim_d     = claim_q;
        rr_d        = rr_q;
        grant       = '0;
        grant_write = '0;
        grant_idx   = '0;
        grant_addr  = '0;
        grant_data  = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            start = 32'(rr_d);
            if (ch_idle[c]) begin
                for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
                    j = start + k;
                    if (j >= NUM_CONSUMERS) begin
                        j = j - NUM_CONSUMERS;
                    end
                    if (!grant[c] && (rd_req[j] || wr_req[j]) && !claim_d[j]) begin
                        grant[c]       = 1'b1;
                        grant_write[c] = !rd_req[j];
                        grant_idx[c]   = IdxW'(j);
                        grant_addr[c]  = rd_req[j] ? consumer_read_address[j]
                                                   : consumer_write_address[j];
                        grant_data[c]  = consumer_write_data[j];
                        claim_d[j]     = 1'b1;
                        rr_d           = (j == NUM_CONSUMERS - 1) ? '0 : IdxW'(j + 1);
                    end
                end
            end
        end
        claim_d = claim_d & ~release_mask;
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        assign ch_rd_v[c] = consumer_read_valid[ch_idx[c]];
        assign ch_wr_v[c] = consumer_write_valid[ch_idx[c]];

        mem_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .IDX_W     (IdxW)
        ) u_channel (
            .clk                 (clk),
            .reset_n             (reset_n),
            .grant_i             (grant[c]),
            .grant_write_i       (grant_write[c]),
            .grant_idx_i         (grant_idx[c]),
            .grant_addr_i        (grant_addr[c]),
            .grant_data_i        (grant_data[c]),
            .cons_read_valid_i   (ch_rd_v[c]),
            .cons_write_valid_i  (ch_wr_v[c]),
            .mem_read_ready_i    (mem_read_ready[c]),
            .mem_read_data_i     (mem_read_data[c]),
            .mem_write_ready_i   (mem_write_ready[c]),
            .idle_o              (ch_idle[c]),
            .release_o           (ch_release[c]),
            .idx_o               (ch_idx[c]),
            .read_ready_o        (ch_rd_rdy[c]),
            .read_data_o         (ch_rdata[c]),
            .write_ready_o       (ch_wr_rdy[c]),
            .mem_read_valid_o    (mem_read_valid[c]),
            .mem_read_address_o  (mem_read_address[c]),
            .mem_write_valid_o   (ch_mwv[c]),
            .mem_write_address_o (ch_mwaddr[c]),
            .mem_write_data_o    (ch_mwdata[c])
        );

        assign mem_write_valid[c]   = WRITE_ENABLE ? ch_mwv[c] : 1'b0;
        assign mem_write_address[c] = WRITE_ENABLE ? ch_mwaddr[c] : '0;
        assign mem_write_data[c]    = WRITE_ENABLE ? ch_mwdata[c] : '0;
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_read_data   = '0;
        consumer_write_ready = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_rd_rdy[c]) begin
                consumer_read_ready[ch_idx[c]] = 1'b1;
                consumer_read_data[ch_idx[c]]  = ch_rdata[c];
            end
            if (ch_wr_rdy[c] && WRITE_ENABLE) begin
                consumer_write_ready[ch_idx[c]] = 1'b1;
            end
        end
    end

endmodule
